mem_arbiter: RTL and testbench

- Shares the single-port 8x8 working memory (3-bit `add`, active-low `wr`, bidirectional 8-bit `data`) between two requesters.
- Requester 0 is the sort controller; requester 1 is the host load/readback port.
- Round-robin arbitration with a per-requester lock, so a read-read-write-write swap sequence runs atomically.
- Every access follows the memory's fixed multi-cycle timing.

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single-port 8x8 memory with fixed
// multi-cycle access timing and an owner lock for atomic access sequences.
module mem_arbiter #(
  parameter int ACC_CYC  = 3,
  parameter int HOLD_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  lock,
  input  logic [1:0]  we,
  input  logic [5:0]  addr,
  input  logic [15:0] wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  ack,
  output logic [7:0]  rdata,
  output logic [2:0]  add,
  output logic        wr,
  inout  wire  [7:0]  data
);

  localparam int ACW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam int HCW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [ACW-1:0] ACC_LAST  = ACW'(ACC_CYC - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_gnt;
  logic [1:0]       r_ack;
  logic [7:0]       r_rdata;
  logic [2:0]       r_add;
  logic             r_we;
  logic [7:0]       r_wdata;
  logic             r_owner;
  logic             r_p;
  logic [ACW-1:0]   r_acc_cnt;
  logic [HCW-1:0]   r_hold_cnt;

  logic             w_win;
  logic             w_load;
  logic             w_acc_done;
  logic             w_to_hold;
  logic             w_hold_inc;
  logic             w_release;
  logic             w_drive;
  logic [7:0]       w_wdata_sel;
  logic [2:0]       w_addr_sel;

  // Next-state and control strobes; in HOLD the other requester is stalled
  always_comb begin
    w_next     = r_state;
    w_win      = r_p;
    w_load     = 1'b0;
    w_acc_done = 1'b0;
    w_to_hold  = 1'b0;
    w_hold_inc = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_win = req[r_p] ? r_p : ~r_p;
        if (req != 2'b00) begin
          w_load = 1'b1;
          w_next = S_ACC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ACC: begin
        if (r_acc_cnt == ACC_LAST) begin
          w_acc_done = 1'b1;
          w_next     = S_RESP;
        end else begin
          w_next = S_ACC;
        end
      end
      S_RESP: begin
        if (lock[r_owner]) begin
          w_to_hold = 1'b1;
          w_next    = S_HOLD;
        end else begin
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_HOLD: begin
        w_win = r_owner;
        if (req[r_owner]) begin
          w_load = 1'b1;
          w_next = S_ACC;
        end else if (!lock[r_owner] || (r_hold_cnt == HOLD_LAST)) begin
          w_release = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_hold_inc = 1'b1;
          w_next     = S_HOLD;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_wdata_sel = w_win ? wdata[15:8] : wdata[7:0];
  assign w_addr_sel  = w_win ? addr[5:3]   : addr[2:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant, payload latch, counters and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt      <= 2'b00;
      r_ack      <= 2'b00;
      r_rdata    <= 8'h00;
      r_add      <= 3'd0;
      r_we       <= 1'b0;
      r_wdata    <= 8'h00;
      r_owner    <= 1'b0;
      r_p        <= 1'b0;
      r_acc_cnt  <= {ACW{1'b0}};
      r_hold_cnt <= {HCW{1'b0}};
    end else begin
      r_ack <= 2'b00;
      if (w_load) begin
        r_owner   <= w_win;
        r_gnt     <= w_win ? 2'b10 : 2'b01;
        r_we      <= we[w_win];
        r_wdata   <= w_wdata_sel;
        r_add     <= w_addr_sel;
        r_acc_cnt <= {ACW{1'b0}};
      end
      if ((r_state == S_ACC) && !w_acc_done) begin
        r_acc_cnt <= r_acc_cnt + ACW'(1);
      end
      // Read data is captured from the bus at the edge closing the access
      if (w_acc_done) begin
        r_ack <= r_owner ? 2'b10 : 2'b01;
        if (!r_we) begin
          r_rdata <= data;
        end
      end
      if (w_to_hold) begin
        r_hold_cnt <= {HCW{1'b0}};
      end
      if (w_hold_inc) begin
        r_hold_cnt <= r_hold_cnt + HCW'(1);
      end
      if (w_release) begin
        r_gnt <= 2'b00;
        r_p   <= ~r_owner;
      end
    end
  end

  assign w_drive = (r_state == S_ACC) && r_we;
  assign wr      = ~w_drive;
  assign data    = w_drive ? r_wdata : 8'hzz;
  assign gnt     = r_gnt;
  assign ack     = r_ack;
  assign rdata   = r_rdata;
  assign add     = r_add;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand-written corner
// sequences, and a randomized two-requester run against a memory model.
module tb_mem_arbiter;

  localparam int ACC_CYC  = 3;
  localparam int HOLD_MAX = 15;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  lock;
  logic [1:0]  we;
  logic [5:0]  addr;
  logic [15:0] wdata;
  wire  [1:0]  gnt;
  wire  [1:0]  ack;
  wire  [7:0]  rdata;
  wire  [2:0]  add;
  wire         wr;
  wire  [7:0]  data;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [8];

  mem_arbiter #(.ACC_CYC(ACC_CYC), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr),
    .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata), .add(add),
    .wr(wr), .data(data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pre(input int k);
    return (k == 5) ? 8'hA7 : 8'(8'h11 * k);
  endfunction

  // Memory model: reloads known contents on reset, drives the bus on reads
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) mem[k] <= pre(k);
    end else if (!wr) begin
      mem[add] <= data;
    end
  end
  assign data = (wr && (gnt != 2'b00)) ? mem[add] : 8'hzz;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    end
  endtask

  task automatic set_req(input int n, input logic r, input logic w,
                         input logic [2:0] a, input logic [7:0] d);
    req[n]            = r;
    we[n]             = w;
    addr[3*n +: 3]    = a;
    wdata[8*n +: 8]   = d;
  endtask

  task automatic wait_ack(input string nm, input int n, input int limit);
    for (int c = 0; c < limit; c++) begin
      step();
      if (ack[n]) break;
    end
    chk(nm, {31'd0, ack[n]}, 32'd1);
  endtask

  typedef struct {
    int         n;
    logic       w;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  // One isolated access with full cycle-by-cycle timing checks
  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    oh = (v.n == 1) ? 2'b10 : 2'b01;
    set_req(v.n, 1'b1, v.w, v.a, v.d);
    for (int c = 1; c <= ACC_CYC; c++) begin
      step();
      if (c == 1) chk("vec_gnt", gnt, oh);
      chk("vec_wr_acc", wr, !v.w);
      if (v.w) chk("vec_data", data, v.d);
      chk("vec_add", add, v.a);
    end
    step();
    chk("vec_ack", ack, oh);
    if (!v.w) chk("vec_rdata", rdata, v.exp);
    chk("vec_wr_resp", wr, 1'b1);
    set_req(v.n, 1'b0, v.w, v.a, v.d);
    step();
    chk("vec_gnt_free", gnt, 2'b00);
    chk("vec_ack_low", ack, 2'b00);
  endtask

  vec_t tbl[8];
  logic [7:0] model_mem [8];
  logic       act   [2];
  logic       rw    [2];
  logic [2:0] ra    [2];
  logic [7:0] rd    [2];
  int         waitc [2];
  int         wr_low;
  int         bad;
  int         own;

  initial begin
    tbl[0] = '{0, 1'b0, 3'd5, 8'h00, 8'hA7};
    tbl[1] = '{1, 1'b1, 3'd2, 8'h3C, 8'h00};
    tbl[2] = '{0, 1'b0, 3'd2, 8'h00, 8'h3C};
    tbl[3] = '{1, 1'b0, 3'd7, 8'h00, 8'h77};
    tbl[4] = '{0, 1'b1, 3'd7, 8'h5A, 8'h00};
    tbl[5] = '{1, 1'b0, 3'd7, 8'h00, 8'h5A};
    tbl[6] = '{1, 1'b1, 3'd0, 8'hFF, 8'h00};
    tbl[7] = '{0, 1'b0, 3'd0, 8'h00, 8'hFF};

    rst = 1'b1; req = 2'b00; lock = 2'b00; we = 2'b00; addr = 6'd0; wdata = 16'h0000;
    step();
    step();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_ack", ack, 2'b00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_add", add, 3'd0);
    chk("rst_wr", wr, 1'b1);
    rst = 1'b0;
    step();

    // Simultaneous requests from reset: pointer starts at requester 0
    set_req(0, 1'b1, 1'b0, 3'd1, 8'h00);
    set_req(1, 1'b1, 1'b0, 3'd6, 8'h00);
    step();
    chk("sim_gnt0", gnt, 2'b01);
    step(); step(); step();
    chk("sim_ack0", ack, 2'b01);
    chk("sim_rdata0", rdata, 8'h11);
    step();
    chk("sim_idle", gnt, 2'b00);
    step();
    chk("sim_gnt1", gnt, 2'b10);
    step(); step(); step();
    chk("sim_ack1", ack, 2'b10);
    chk("sim_rdata1", rdata, 8'h66);
    set_req(1, 1'b0, 1'b0, 3'd6, 8'h00);
    step();
    chk("sim_idle2", gnt, 2'b00);
    step();
    chk("sim_gnt0_again", gnt, 2'b01);
    wait_ack("sim_ack0_again", 0, 8);
    set_req(0, 1'b0, 1'b0, 3'd1, 8'h00);
    step();

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Locked read-read-write-write swap of addresses 3 and 4
    lock[0] = 1'b1;
    set_req(0, 1'b1, 1'b0, 3'd3, 8'h00);
    step();
    chk("swap_gnt", gnt, 2'b01);
    set_req(1, 1'b1, 1'b0, 3'd5, 8'h00);
    wait_ack("swap_ack_r3", 0, 8);
    chk("swap_rd3", rdata, 8'h33);
    set_req(0, 1'b1, 1'b0, 3'd4, 8'h00);
    wait_ack("swap_ack_r4", 0, 8);
    chk("swap_gnt_r4", gnt, 2'b01);
    chk("swap_rd4", rdata, 8'h44);
    set_req(0, 1'b1, 1'b1, 3'd3, 8'h44);
    wait_ack("swap_ack_w3", 0, 8);
    chk("swap_gnt_w3", gnt, 2'b01);
    set_req(0, 1'b1, 1'b1, 3'd4, 8'h33);
    wait_ack("swap_ack_w4", 0, 8);
    chk("swap_gnt_w4", gnt, 2'b01);
    set_req(0, 1'b0, 1'b0, 3'd4, 8'h00);
    lock[0] = 1'b0;
    step();
    chk("swap_release", gnt, 2'b00);
    step();
    chk("swap_gnt1", gnt, 2'b10);
    wait_ack("swap_ack1", 1, 8);
    chk("swap_rd1", rdata, 8'hA7);
    set_req(1, 1'b0, 1'b0, 3'd5, 8'h00);
    step();
    run_vec('{1, 1'b0, 3'd3, 8'h00, 8'h44});
    run_vec('{0, 1'b0, 3'd4, 8'h00, 8'h33});

    // Locked owner goes idle: forced release after HOLD_MAX cycles
    lock[0] = 1'b1;
    set_req(0, 1'b1, 1'b0, 3'd1, 8'h00);
    step();
    chk("hold_gnt", gnt, 2'b01);
    set_req(1, 1'b1, 1'b0, 3'd2, 8'h00);
    wait_ack("hold_ack0", 0, 8);
    chk("hold_rd0", rdata, 8'h11);
    set_req(0, 1'b0, 1'b0, 3'd1, 8'h00);
    bad = 0;
    for (int k = 0; k < HOLD_MAX; k++) begin
      step();
      if (gnt != 2'b01) bad++;
    end
    chk("hold_kept_cycles", bad, 0);
    step();
    chk("hold_forced_release", gnt, 2'b00);
    lock[0] = 1'b0;
    step();
    chk("hold_gnt1", gnt, 2'b10);
    wait_ack("hold_ack1", 1, 8);
    chk("hold_rd1", rdata, 8'h3C);
    set_req(1, 1'b0, 1'b0, 3'd2, 8'h00);
    step();

    // Reset during the second cycle of a write
    set_req(1, 1'b1, 1'b1, 3'd6, 8'h99);
    step();
    chk("rstw_wr_low", wr, 1'b0);
    step();
    chk("rstw_wr_low2", wr, 1'b0);
    rst = 1'b1;
    step();
    chk("rstw_wr", wr, 1'b1);
    chk("rstw_gnt", gnt, 2'b00);
    chk("rstw_ack", ack, 2'b00);
    rst = 1'b0;
    set_req(1, 1'b0, 1'b0, 3'd6, 8'h00);
    step();
    step();
    chk("rstw_idle_gnt", gnt, 2'b00);

    // Randomized traffic from both requesters against an array model
    for (int k = 0; k < 8; k++) model_mem[k] = pre(k);
    for (int n = 0; n < 2; n++) begin
      act[n] = 1'b0; rw[n] = 1'b0; ra[n] = 3'd0; rd[n] = 8'h00; waitc[n] = 0;
    end
    wr_low = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      chk("rnd_gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      if (!wr) begin
        wr_low++;
        own = (gnt == 2'b10) ? 1 : 0;
        chk("rnd_wdata_bus", data, rd[own]);
      end
      for (int n = 0; n < 2; n++) begin
        if (ack[n]) begin
          chk("rnd_ack_owner", {31'd0, act[n]}, 32'd1);
          if (rw[n]) model_mem[ra[n]] = rd[n];
          else chk("rnd_rdata", rdata, model_mem[ra[n]]);
          chk("rnd_wr_cycles", wr_low, rw[n] ? ACC_CYC : 0);
          chk("rnd_latency", {31'd0, (waitc[n] <= 10)}, 32'd1);
          wr_low = 0;
          act[n] = 1'b0;
          req[n] = 1'b0;
        end else if (act[n]) begin
          waitc[n]++;
        end
      end
      if (cyc < 360) begin
        for (int n = 0; n < 2; n++) begin
          if (!act[n] && ($urandom_range(0, 2) != 0)) begin
            act[n]   = 1'b1;
            waitc[n] = 0;
            rw[n]    = 1'($urandom_range(0, 1));
            ra[n]    = 3'($urandom_range(0, 7));
            rd[n]    = 8'($urandom);
            set_req(n, 1'b1, rw[n], ra[n], rd[n]);
          end
        end
      end
    end
    chk("rnd_drain", {30'd0, act[1], act[0]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
